// File: rtl/codificador_gray_pkg.sv
// rtl/codificador_gray_pkg.sv - shared Gray helpers, default width and direction encodings
//
// Purpose : definitions shared by the Gray encoder, the Gray decoder/display path
//           and the display refresh logic.
// Contents: N_DEFAULT     default data width
//           DIR_UP/DOWN   encodings of the count-direction input
//           bin2gray      binary -> reflected Gray (up to 32 bits)
//           gray2bin      reflected Gray -> binary (up to 32 bits, used by the decoder)
package codificador_gray_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Zero-extended operands work for any width up to 32: the extra high
    // bits stay 0 and do not disturb the low N bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/codificador_gray_divisor_tick.sv
// rtl/codificador_gray_divisor_tick.sv - enable-gated prescaler producing a one-cycle tick
//
// Purpose : counts 0..DIV-1 on enabled cycles and flags the last phase.
// Params  : DIV  clock cycles per tick while enabled (>= 1)
// Ports   : clk   system clock, rising edge
//           rst   synchronous reset, active-high
//           en    run enable; low freezes the phase and suppresses the tick
//           clr   synchronous clear of the phase (lower priority than rst)
//           tick  combinational, high when en and phase == DIV-1
module divisor_tick #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    // With DIV = 1 the phase never leaves 0, so every enabled cycle ticks.
    assign tick = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/codificador_gray.sv
// rtl/codificador_gray.sv - prescaled up/down counter with parallel load, Gray and binary outputs
//
// Purpose : Gray-code stimulus source for the board-level Gray link.
// Params  : N    data width (>= 2)
//           DIV  clock cycles per step while enabled (>= 1)
// Macro   : CODIFICADOR_GRAY_SATURA_EN - when defined, steps saturate at 0 and
//           2^N-1 instead of wrapping; the prescaler keeps running.
// Ports   : clk_pi             system clock, rising edge
//           rst_pi             synchronous reset, active-high
//           en_pi              run enable (freezes prescaler and counter when low)
//           dir_pi             1 = up, 0 = down, used on step cycles only
//           load_pi            parallel load strobe (overrides a same-cycle step)
//           codigo_bin_pi      value to load
//           codigo_gray_po     registered Gray code of the count
//           codigo_bin_led_po  registered binary count
//           paso_po            one-cycle pulse when the outputs show a stepped value
//           vuelta_po          one-cycle pulse when a step wrapped
module codificador_gray
    import codificador_gray_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int DIV = 5
) (
    input  logic         clk_pi,
    input  logic         rst_pi,
    input  logic         en_pi,
    input  logic         dir_pi,
    input  logic         load_pi,
    input  logic [N-1:0] codigo_bin_pi,
    output logic [N-1:0] codigo_gray_po,
    output logic [N-1:0] codigo_bin_led_po,
    output logic         paso_po,
    output logic         vuelta_po
);

    localparam logic [N-1:0] MAX = '1;

    logic         tick;
    logic [N-1:0] count;
    logic [N-1:0] gray;
    logic         paso;
    logic         vuelta;
    logic [N-1:0] stepped;
    logic         at_edge;

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] v);
        return N'(bin2gray(32'(v)));
    endfunction

    // A load restarts the step phase so the next step lands a full DIV
    // enabled cycles after it.
    divisor_tick #(
        .DIV (DIV)
    ) u_divisor_tick (
        .clk  (clk_pi),
        .rst  (rst_pi),
        .en   (en_pi),
        .clr  (load_pi),
        .tick (tick)
    );

    // at_edge: the step in the requested direction would cross the wrap point.
    always_comb begin
        stepped = count;
        at_edge = 1'b0;
        if (dir_pi == DIR_UP) begin
            stepped = count + 1'b1;
            at_edge = (count == MAX);
        end else begin
            stepped = count - 1'b1;
            at_edge = (count == '0);
        end
    end

    // Gray and binary registers load from the same next value on the same
    // edge, so the two outputs never skew against each other.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            count  <= '0;
            gray   <= '0;
            paso   <= 1'b0;
            vuelta <= 1'b0;
        end else if (load_pi) begin
            count  <= codigo_bin_pi;
            gray   <= to_gray(codigo_bin_pi);
            paso   <= 1'b0;
            vuelta <= 1'b0;
        end else if (tick) begin
`ifdef CODIFICADOR_GRAY_SATURA_EN
            if (at_edge) begin
                paso   <= 1'b0;
                vuelta <= 1'b0;
            end else begin
                count  <= stepped;
                gray   <= to_gray(stepped);
                paso   <= 1'b1;
                vuelta <= 1'b0;
            end
`else
            count  <= stepped;
            gray   <= to_gray(stepped);
            paso   <= 1'b1;
            vuelta <= at_edge;
`endif
        end else begin
            paso   <= 1'b0;
            vuelta <= 1'b0;
        end
    end

    assign codigo_gray_po    = gray;
    assign codigo_bin_led_po = count;
    assign paso_po           = paso;
    assign vuelta_po         = vuelta;

endmodule

// File: tb/tb_codificador_gray.sv
// tb/tb_codificador_gray.sv - self-checking bench for codificador_gray against a behavioural model
module tb_codificador_gray;

    localparam int N   = 4;
    localparam int DIV = 5;
    localparam int M   = 1 << N;

    logic         clk = 1'b0;
    logic         rst_pi = 1'b0;
    logic         en_pi = 1'b0;
    logic         dir_pi = 1'b0;
    logic         load_pi = 1'b0;
    logic [N-1:0] codigo_bin_pi = '0;
    logic [N-1:0] codigo_gray_po;
    logic [N-1:0] codigo_bin_led_po;
    logic         paso_po;
    logic         vuelta_po;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // model state
    int m_cnt = 0;
    int m_pres = 0;
    int m_paso = 0;
    int m_vuelta = 0;

    codificador_gray #(.N(N), .DIV(DIV)) dut (
        .clk_pi            (clk),
        .rst_pi            (rst_pi),
        .en_pi             (en_pi),
        .dir_pi            (dir_pi),
        .load_pi           (load_pi),
        .codigo_bin_pi     (codigo_bin_pi),
        .codigo_gray_po    (codigo_gray_po),
        .codigo_bin_led_po (codigo_bin_led_po),
        .paso_po           (paso_po),
        .vuelta_po         (vuelta_po)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray_of(input int v);
        return v ^ (v / 2);
    endfunction

    // Applies one cycle of inputs, advances the model by the spec's rules,
    // then compares all outputs just after the edge.
    task automatic cyc(input bit r, input bit e, input bit d, input bit l, input int b);
        logic [N-1:0] g_before;
        int tick;
        int nxt;
        bit wrap;
        rst_pi = r; en_pi = e; dir_pi = d; load_pi = l; codigo_bin_pi = b[N-1:0];
        if (r) begin
            m_cnt = 0; m_pres = 0; m_paso = 0; m_vuelta = 0;
        end else if (l) begin
            m_cnt = b % M; m_pres = 0; m_paso = 0; m_vuelta = 0;
        end else begin
            tick = (e && m_pres == DIV - 1) ? 1 : 0;
            if (e) m_pres = (m_pres + 1) % DIV;
            m_paso = 0; m_vuelta = 0;
            if (tick != 0) begin
                nxt  = d ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
                wrap = d ? (m_cnt == M - 1) : (m_cnt == 0);
`ifdef CODIFICADOR_GRAY_SATURA_EN
                if (!wrap) begin
                    m_cnt = nxt; m_paso = 1;
                end
`else
                m_cnt = nxt; m_paso = 1; m_vuelta = wrap ? 1 : 0;
`endif
            end
        end
        g_before = codigo_gray_po;
        @(posedge clk);
        #1;
        check("bin",    32'(codigo_bin_led_po), 32'(m_cnt));
        check("gray",   32'(codigo_gray_po),    32'(gray_of(m_cnt)));
        check("paso",   32'(paso_po),           32'(m_paso));
        check("vuelta", 32'(vuelta_po),         32'(m_vuelta));
        if (m_paso != 0) begin
            check("one_bit_step", 32'($countones(g_before ^ codigo_gray_po)), 32'd1);
        end
        if (paso_po === 1'b1) pulses++;
    endtask

    initial begin
        // 1: reset dominates en and load
        cyc(1, 1, 0, 1, 5);
        cyc(1, 1, 0, 1, 5);
        check("reset_gray", 32'(codigo_gray_po), 32'd0);

        // 2: count up from 0, four steps in 20 cycles
        pulses = 0;
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0);
        check("up_gray_0110", 32'(codigo_gray_po), 32'h6);
        check("up_pulses", 32'(pulses), 32'd4);

        // 3: load 1111, step up (wrap), then step down (wrap back)
        cyc(0, 1, 1, 1, 15);
        check("load15_gray", 32'(codigo_gray_po), 32'h8);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);

        // 4: load coincident with a tick (prescaler at DIV-1)
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 6);
        check("load6_gray", 32'(codigo_gray_po), 32'h5);
        check("load6_paso", 32'(paso_po), 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        check("load6_next_step", 32'(paso_po), 32'd1);

        // 5: freeze at phase 3, toggle dir while frozen, resume
        cyc(0, 1, 1, 1, 6);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, (i >= 3), 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("resume_no_step", 32'(paso_po), 32'd0);
        cyc(0, 1, 0, 0, 0);
        check("resume_step", 32'(paso_po), 32'd1);

        // 6: boundary behaviour up at max and down at zero for 3 ticks each
        cyc(0, 1, 1, 1, 15);
        for (int i = 0; i < 3 * DIV; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 3 * DIV; i++) cyc(0, 1, 0, 0, 0);

        // reset mid-count
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, M - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
